// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive control path.
package uart_rx_pkg;

  localparam int unsigned StateW = 3;

  // Receive controller states. Encodings 6 and 7 are unused and decode to idle.
  typedef enum logic [StateW-1:0] {
    StIdle    = 3'd0,
    StStart   = 3'd1,
    StData    = 3'd2,
    StStop    = 3'd3,
    StCleanup = 3'd4,
    StBreak   = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl.sv
// UART receive control FSM. It sequences uart_rx_datapath from that block's
// status flags. It also rejects start-bit glitches, checks the stop bit, holds
// off during a line break and keeps a saturating framing-error count.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_bit,
  input  logic                 half_bit_width,
  input  logic                 full_bit_width,
  input  logic                 last_bit,
  output logic                 en_clk_count,
  output logic                 s_clk_count,
  output logic                 en_bit_index,
  output logic                 s_bit_index,
  output logic                 en_rx_valid,
  output logic                 s_rx_valid,
  output logic                 en_rx_byte,
  output logic                 busy,
  output logic                 frame_error,
  output logic [ERR_CNT_W-1:0] err_count
);

  rx_state_e            state_q, state_d;
  logic                 frame_error_q, frame_error_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 err_inc;

  // State, error pulse and error counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      frame_error_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      frame_error_q <= frame_error_d;
      err_count_q   <= err_count_d;
    end
  end

  // Next state plus Mealy strobes, so the datapath acts on the edge the flag is seen.
  always_comb begin
    state_d       = state_q;
    frame_error_d = 1'b0;
    err_inc       = 1'b0;
    en_clk_count  = 1'b0;
    s_clk_count   = 1'b0;
    en_bit_index  = 1'b0;
    s_bit_index   = 1'b0;
    en_rx_valid   = 1'b0;
    s_rx_valid    = 1'b0;
    en_rx_byte    = 1'b0;

    if (reset) begin
      // The datapath has no reset of its own, so clear it through the strobes.
      en_clk_count = 1'b1;
      en_bit_index = 1'b1;
      en_rx_valid  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          en_clk_count = 1'b1;
          en_bit_index = 1'b1;
          en_rx_valid  = 1'b1;
          if (start_bit) state_d = StStart;
        end
        StStart: begin
          en_clk_count = 1'b1;
          s_clk_count  = 1'b1;
          if (half_bit_width) begin
            if (start_bit) begin
              s_clk_count = 1'b0;
              state_d     = StData;
            end else begin
              // The line went high before mid start bit: treat it as noise.
              state_d = StIdle;
            end
          end
        end
        StData: begin
          en_clk_count = 1'b1;
          s_clk_count  = 1'b1;
          if (full_bit_width) begin
            s_clk_count  = 1'b0;
            en_rx_byte   = 1'b1;
            en_bit_index = 1'b1;
            if (last_bit) begin
              state_d = StStop;
            end else begin
              s_bit_index = 1'b1;
            end
          end
        end
        StStop: begin
          en_clk_count = 1'b1;
          s_clk_count  = 1'b1;
          if (full_bit_width) begin
            s_clk_count = 1'b0;
            if (!start_bit) begin
              en_rx_valid = 1'b1;
              s_rx_valid  = 1'b1;
              state_d     = StCleanup;
            end else begin
              frame_error_d = 1'b1;
              err_inc       = 1'b1;
              state_d       = StBreak;
            end
          end
        end
        StCleanup: begin
          en_rx_valid = 1'b1;
          state_d     = StIdle;
        end
        StBreak: begin
          // Wait for the line to go idle, so a held-low line reports only one error.
          en_clk_count = 1'b1;
          if (!start_bit) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Saturating increment of the framing-error count.
  always_comb begin
    err_count_d = err_count_q;
    if (err_inc && (err_count_q != '1)) err_count_d = err_count_q + ERR_CNT_W'(1);
  end

  assign busy        = (state_q != StIdle);
  assign frame_error = frame_error_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl. It holds a behavioural uart_rx_datapath at 217 clk/bit.
// A second controller built with a 2-bit error counter runs on the same inputs.
module tb_uart_rx_ctrl;
  localparam int unsigned Cpb      = 217;
  localparam int unsigned HalfCnt  = (Cpb - 1) / 2;
  localparam int unsigned FrameLat = HalfCnt + 9 * Cpb + 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic line  = 1'b1;
  always #5 clk = ~clk;

  // Datapath model
  logic        line_q = 1'b1;
  logic [15:0] clk_count;
  logic [2:0]  bit_index;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        start_bit, half_bit_width, full_bit_width, last_bit;

  assign start_bit      = ~line_q;
  assign half_bit_width = (clk_count == 16'(HalfCnt));
  assign full_bit_width = (clk_count == 16'(Cpb - 1));
  assign last_bit       = (bit_index == 3'd7);

  logic       en_clk_count, s_clk_count, en_bit_index, s_bit_index;
  logic       en_rx_valid, s_rx_valid, en_rx_byte, busy, frame_error;
  logic [7:0] err_count;

  logic       e2_en_clk_count, e2_s_clk_count, e2_en_bit_index, e2_s_bit_index;
  logic       e2_en_rx_valid, e2_s_rx_valid, e2_en_rx_byte, e2_busy, e2_frame_error;
  logic [1:0] err_count2;

  uart_rx_ctrl #(.ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start_bit(start_bit), .half_bit_width(half_bit_width),
    .full_bit_width(full_bit_width), .last_bit(last_bit), .en_clk_count(en_clk_count),
    .s_clk_count(s_clk_count), .en_bit_index(en_bit_index), .s_bit_index(s_bit_index),
    .en_rx_valid(en_rx_valid), .s_rx_valid(s_rx_valid), .en_rx_byte(en_rx_byte),
    .busy(busy), .frame_error(frame_error), .err_count(err_count)
  );

  uart_rx_ctrl #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start_bit(start_bit), .half_bit_width(half_bit_width),
    .full_bit_width(full_bit_width), .last_bit(last_bit), .en_clk_count(e2_en_clk_count),
    .s_clk_count(e2_s_clk_count), .en_bit_index(e2_en_bit_index),
    .s_bit_index(e2_s_bit_index), .en_rx_valid(e2_en_rx_valid), .s_rx_valid(e2_s_rx_valid),
    .en_rx_byte(e2_en_rx_byte), .busy(e2_busy), .frame_error(e2_frame_error),
    .err_count(err_count2)
  );

  always @(posedge clk) begin
    line_q <= line;
    if (en_clk_count) clk_count <= s_clk_count ? clk_count + 16'd1 : 16'd0;
    if (en_bit_index) bit_index <= s_bit_index ? bit_index + 3'd1 : 3'd0;
    if (en_rx_valid) rx_valid <= s_rx_valid;
    if (en_rx_byte) rx_byte[bit_index] <= line_q;
  end

  // Monitor: cycle count, received bytes, pulse bookkeeping
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  got_q[$];
  int unsigned rv_cyc = 0, fe_pulses = 0, rv_double = 0, fe_double = 0;
  logic        rv_prev = 1'b0, fe_prev = 1'b0;
  always @(negedge clk) begin
    rv_prev <= rx_valid;
    fe_prev <= frame_error;
    if (rx_valid === 1'b1) begin
      got_q.push_back(rx_byte);
      if (rv_prev) rv_double <= rv_double + 1;
      else rv_cyc <= cyc;
    end
    if (frame_error === 1'b1) begin
      if (fe_prev) fe_double <= fe_double + 1;
      else fe_pulses <= fe_pulses + 1;
    end
  end

  // Scoreboard and checking
  int unsigned checks = 0, errors = 0;
  logic [7:0]  exp_q[$];
  int unsigned rd_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    logic [7:0] exp_b;
    while (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      if (rd_idx < got_q.size()) begin
        check(tag, 32'(got_q[rd_idx]), 32'(exp_b));
        rd_idx++;
      end else begin
        check({tag, "_missing"}, got_q.size(), rd_idx + 1);
      end
    end
    check({tag, "_extra"}, got_q.size(), rd_idx);
  endtask

  task automatic drive(input logic v, input int unsigned n);
    line = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    drive(1'b0, Cpb);
    for (int i = 0; i < 8; i++) drive(b[i], Cpb);
    drive(stop_v, Cpb);
  endtask

  int unsigned t0, fe0;
  logic [1:0]  exp2_tab[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    // Reset: strobes clear the datapath
    repeat (3) @(posedge clk);
    #1;
    check("rst_en_clk", {en_clk_count, s_clk_count}, 2'b10);
    check("rst_en_bit", {en_bit_index, s_bit_index}, 2'b10);
    check("rst_en_rxv", {en_rx_valid, s_rx_valid, en_rx_byte}, 3'b100);
    reset = 1'b0;
    drive(1'b1, 5);
    check("rst_busy", busy, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_err_count", err_count, 0);
    check("rst_rx_valid", rx_valid, 0);

    // 0xA5 with latency measurement
    t0 = cyc;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    drive(1'b1, 20);
    check("a5_latency", rv_cyc - t0, FrameLat);
    drain("a5_byte");
    check("a5_busy", busy, 0);
    check("a5_fe", fe_pulses, 0);

    // 50-clock glitch on idle line
    drive(1'b0, 50);
    check("glitch_busy_mid", busy, 1);
    drive(1'b1, 70);
    check("glitch_busy_end", busy, 0);
    check("glitch_no_rxv", got_q.size(), rd_idx);
    check("glitch_err_count", err_count, 0);

    // 0x3C with bad stop bit, line held low
    fe0 = fe_pulses;
    send_byte(8'h3C, 1'b0);
    drive(1'b0, 3000);
    check("brk_fe_pulses", fe_pulses - fe0, 1);
    check("brk_err_count", err_count, 1);
    check("brk_busy_low", busy, 1);
    check("brk_no_rxv", got_q.size(), rd_idx);
    drive(1'b1, 20);
    check("brk_busy_high", busy, 0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    drive(1'b1, 20);
    drain("after_brk_5a");

    // Back-to-back frames
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h81, 1'b1);
    drive(1'b1, 20);
    drain("b2b");

    // Reset in the middle of bit 4 of 0x77; transmitter abandons the frame
    drive(1'b0, Cpb);
    for (int i = 0; i < 4; i++) drive(1'(8'h77 >> i), Cpb);
    drive(1'b1, Cpb / 2);
    check("mid_busy_before", busy, 1);
    reset = 1'b1;
    drive(1'b1, 1);
    reset = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_clk_count", clk_count, 0);
    check("mid_bit_index", bit_index, 0);
    check("mid_err_count", err_count, 0);
    drive(1'b1, 12 * Cpb);
    check("mid_no_rxv", got_q.size(), rd_idx);
    check("mid_no_fe", fe_pulses - fe0, 1);
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    drive(1'b1, 20);
    drain("mid_12");

    // Saturation of the 2-bit counter
    check("sat_start", err_count2, 0);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h3C, 1'b0);
      drive(1'b0, 300);
      drive(1'b1, 300);
      check($sformatf("sat_w2_%0d", i), err_count2, exp2_tab[i]);
      check($sformatf("sat_w8_%0d", i), err_count, i + 1);
    end
    check("sat_no_rxv", got_q.size(), rd_idx);

    // Pulse-width bookkeeping over the whole run
    check("rxv_one_cycle", rv_double, 0);
    check("fe_one_cycle", fe_double, 0);
    check("fe_total", fe_pulses, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
